axi4s_elastic_buffer: RTL and testbench
=======================================

AXI4S_ELASTIC_BUFFER -- requirements
Module: axi4s_elastic_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, tdata width in bits (>=8, multiple of 8).
REQ-002 SHALL have parameter USER_WIDTH, default 1, tuser width in bits (>=1).
REQ-003 SHALL have parameter DEPTH, default 4, beats of storage (power of 2, >=2).
REQ-004 SHALL have parameter PACKET_MODE, default 0; when 1, output is gated until a complete packet is stored.
REQ-005 SHALL have parameter AFULL_THRESH, default DEPTH-1, occupancy at or above which almost_full_o asserts.
REQ-006 clk_i  input  1  single clock, all logic on rising edge.
REQ-007 rst_ni  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-008 m_tdata_i  input  DATA_WIDTH  upstream data.
REQ-009 m_tkeep_i  input  DATA_WIDTH/8  upstream byte enables, carried unmodified.
REQ-010 m_tuser_i  input  USER_WIDTH  upstream sideband, carried unmodified.
REQ-011 m_tlast_i  input  1  upstream end of packet.
REQ-012 m_tvalid_i  input  1  upstream valid.
REQ-013 m_tready_o  output  1  upstream ready, driven from a register.
REQ-014 s_tdata_o / s_tkeep_o / s_tuser_o / s_tlast_o  output  DATA_WIDTH / DATA_WIDTH/8 / USER_WIDTH / 1  downstream beat.
REQ-015 s_tvalid_o  output  1  downstream valid, driven from registers.
REQ-016 s_tready_i  input  1  downstream ready.
REQ-017 level_o  output  $clog2(DEPTH)+1  beats currently stored.
REQ-018 almost_full_o  output  1  registered, level >= AFULL_THRESH.

Function
REQ-019 Push SHALL occur on an edge where m_tvalid_i && m_tready_o; pop on an edge where s_tvalid_o && s_tready_i.
REQ-020 Storage SHALL be a circular buffer with rd/wr pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, plus a level counter.
REQ-021 level SHALL update +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; never exceed DEPTH, never underflow.
REQ-022 m_tready_o SHALL equal (level < DEPTH) as registered after each edge; no combinational path from s_tready_i to m_tready_o.
REQ-023 When full, a pop SHALL deassert-to-assert m_tready_o on the following cycle (one-cycle bubble at full is accepted); below full, sustained push+pop SHALL give 1 beat/cycle.
REQ-024 Latency SHALL be 1 cycle: a beat pushed at edge N is presented on s_* in the cycle after edge N when buffer was empty (PACKET_MODE=0).
REQ-025 s_* data outputs SHALL present the entry at rd_ptr; beat order, tkeep, tuser and tlast SHALL be preserved exactly.
REQ-026 While s_tvalid_o=1 and s_tready_i=0, all s_* outputs SHALL remain stable.
REQ-027 PACKET_MODE=0: s_tvalid_o SHALL equal (level != 0).
REQ-028 PACKET_MODE=1: a packet counter SHALL increment on push with tlast, decrement on pop with tlast (net zero when both); s_tvalid_o SHALL equal level!=0 && (pkt_count!=0 || level==DEPTH).
REQ-029 PACKET_MODE=1 full-without-tlast SHALL release beats (deadlock escape) and the gate SHALL remain open until the tlast of that packet pops.
REQ-030 Beats offered with m_tready_o=0 SHALL be neither stored nor dropped silently (upstream holds per AXI4-Stream).

Reset
REQ-031 Assertion of rst_ni=0 SHALL immediately clear pointers, level, packet counter; m_tready_o=0, s_tvalid_o=0, almost_full_o=0, level_o=0.
REQ-032 Storage array SHALL not be reset; s_tdata/tkeep/tuser/tlast are don't-care while s_tvalid_o=0.
REQ-033 m_tready_o SHALL assert on the first edge after rst_ni deasserts; reset mid-packet SHALL discard all stored beats.

Structure
REQ-034 A shared package axi4s_pkg SHALL hold the beat struct typedef parameterless helpers (keep-width function); module-specific parameters stay local.
REQ-035 Storage, pointers and gating SHALL be in one module; no sub-module required.

Verification
REQ-036 DEPTH=4, push 0x11,0x22,0x33 back-to-back, s_tready_i=1 -> outputs 0x11,0x22,0x33 one cycle after each push, level_o max 1.
REQ-037 s_tready_i=0, push 5 beats -> 4 accepted, m_tready_o=0 after 4th, almost_full_o=1 at level 3; release -> 4 beats in order, then 5th.
REQ-038 Random valid/ready 10k beats, DEPTH=8, random tkeep/tuser -> scoreboard exact match, s_* stable while stalled.
REQ-039 PACKET_MODE=1, push 3-beat packet with 2-cycle gaps -> s_tvalid_o=0 until tlast stored, then 3 contiguous beats.
REQ-040 PACKET_MODE=1, DEPTH=4, 6-beat packet, s_tready_i=1 -> output opens at level 4, all 6 beats delivered, no deadlock.
REQ-041 Assert rst_ni=0 mid-packet with level 3 asynchronously -> s_tvalid_o, m_tready_o, level_o zero before next edge; m_tready_o=1 after first edge post-release.

Source files
------------

// File: rtl/axi4s_pkg.sv
// axi4s_pkg: helpers shared by the AXI4-Stream blocks
package axi4s_pkg;
    function automatic int keep_width(int data_width);
        return data_width / 8;
    endfunction
endpackage

// File: rtl/axi4s_elastic_buffer.sv
// axi4s_elastic_buffer: AXI4-Stream circular FIFO with registered handshakes
// and optional store-and-forward gating of whole packets
module axi4s_elastic_buffer
    import axi4s_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 1,
    parameter int DEPTH        = 4,
    parameter int PACKET_MODE  = 0,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_WIDTH-1:0]      m_tdata_i,
    input  logic [DATA_WIDTH/8-1:0]    m_tkeep_i,
    input  logic [USER_WIDTH-1:0]      m_tuser_i,
    input  logic                       m_tlast_i,
    input  logic                       m_tvalid_i,
    output logic                       m_tready_o,
    output logic [DATA_WIDTH-1:0]      s_tdata_o,
    output logic [DATA_WIDTH/8-1:0]    s_tkeep_o,
    output logic [USER_WIDTH-1:0]      s_tuser_o,
    output logic                       s_tlast_o,
    output logic                       s_tvalid_o,
    input  logic                       s_tready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       almost_full_o
);
    localparam int KW = keep_width(DATA_WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KW-1:0]         keep;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } beat_t;

    beat_t         mem [DEPTH];
    beat_t         head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_n, pkt, pkt_n;
    logic          open_q, open_n, push, pop;

    assign push    = m_tvalid_i && m_tready_o;
    assign pop     = s_tvalid_o && s_tready_i;
    assign head    = mem[rd_ptr];
    assign {s_tdata_o, s_tkeep_o, s_tuser_o, s_tlast_o} = head;
    assign level_o = level;

    // open_q holds the gate open after a full-without-tlast escape until that packet's tlast leaves
    always_comb begin
        level_n = level + LW'(push) - LW'(pop);
        pkt_n   = pkt + LW'(push && m_tlast_i) - LW'(pop && head.last);
        open_n  = (pop && head.last) ? 1'b0 : (open_q || level == LW'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            pkt           <= '0;
            open_q        <= 1'b0;
            m_tready_o    <= 1'b0;
            s_tvalid_o    <= 1'b0;
            almost_full_o <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr + AW'(push);
            rd_ptr        <= rd_ptr + AW'(pop);
            level         <= level_n;
            pkt           <= pkt_n;
            open_q        <= open_n;
            m_tready_o    <= level_n < LW'(DEPTH);
            almost_full_o <= int'(level_n) >= AFULL_THRESH;
            s_tvalid_o    <= (level_n != '0) &&
                             (PACKET_MODE == 0 || pkt_n != '0 || level_n == LW'(DEPTH) || open_n);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {m_tdata_i, m_tkeep_i, m_tuser_i, m_tlast_i};
    end
endmodule

// File: tb/tb_axi4s_elastic_buffer.sv
// tb_axi4s_elastic_buffer: scoreboard bench over three buffer configurations
`timescale 1ns/1ps
module tb_axi4s_elastic_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] m_data [3];
    logic [63:0] s_data [3];
    logic [7:0]  m_keep [3];
    logic [7:0]  s_keep [3];
    logic [1:0]  m_user [3];
    logic [1:0]  s_user [3];
    logic        m_last [3];
    logic        m_valid [3];
    logic        m_ready [3];
    logic        s_last [3];
    logic        s_valid [3];
    logic        s_ready [3];
    logic        afull [3];
    logic [2:0]  lvl0, lvl2;
    logic [3:0]  lvl1;

    int          n_cmp = 0, n_err = 0, cyc = 0, max_lvl0 = 0;
    bit          lat_chk = 0, done = 0;
    logic [74:0] exp_q [3][$];
    int          cyc_q [3][$];
    logic [75:0] prev_out [3];
    bit          prev_stall [3];

    // u_dut0: plain FIFO, depth 4; u_dut1: depth 8; u_dut2: packet mode, depth 4
    axi4s_elastic_buffer #(.DATA_WIDTH(64), .USER_WIDTH(2), .DEPTH(4), .PACKET_MODE(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .m_tdata_i(m_data[0]), .m_tkeep_i(m_keep[0]), .m_tuser_i(m_user[0]), .m_tlast_i(m_last[0]),
        .m_tvalid_i(m_valid[0]), .m_tready_o(m_ready[0]),
        .s_tdata_o(s_data[0]), .s_tkeep_o(s_keep[0]), .s_tuser_o(s_user[0]), .s_tlast_o(s_last[0]),
        .s_tvalid_o(s_valid[0]), .s_tready_i(s_ready[0]), .level_o(lvl0), .almost_full_o(afull[0]));

    axi4s_elastic_buffer #(.DATA_WIDTH(64), .USER_WIDTH(2), .DEPTH(8), .PACKET_MODE(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .m_tdata_i(m_data[1]), .m_tkeep_i(m_keep[1]), .m_tuser_i(m_user[1]), .m_tlast_i(m_last[1]),
        .m_tvalid_i(m_valid[1]), .m_tready_o(m_ready[1]),
        .s_tdata_o(s_data[1]), .s_tkeep_o(s_keep[1]), .s_tuser_o(s_user[1]), .s_tlast_o(s_last[1]),
        .s_tvalid_o(s_valid[1]), .s_tready_i(s_ready[1]), .level_o(lvl1), .almost_full_o(afull[1]));

    axi4s_elastic_buffer #(.DATA_WIDTH(64), .USER_WIDTH(2), .DEPTH(4), .PACKET_MODE(1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .m_tdata_i(m_data[2]), .m_tkeep_i(m_keep[2]), .m_tuser_i(m_user[2]), .m_tlast_i(m_last[2]),
        .m_tvalid_i(m_valid[2]), .m_tready_o(m_ready[2]),
        .s_tdata_o(s_data[2]), .s_tkeep_o(s_keep[2]), .s_tuser_o(s_user[2]), .s_tlast_o(s_last[2]),
        .s_tvalid_o(s_valid[2]), .s_tready_i(s_ready[2]), .level_o(lvl2), .almost_full_o(afull[2]));

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Handshakes are observed on the falling edge and take effect on the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) prev_stall[i] = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [75:0] cur;
                logic [74:0] e;
                int          pc;
                cur = {s_valid[i], s_data[i], s_keep[i], s_user[i], s_last[i]};
                if (prev_stall[i]) chk($sformatf("stable%0d", i), cur, prev_out[i]);
                prev_out[i]   = cur;
                prev_stall[i] = s_valid[i] && !s_ready[i];
                if (s_valid[i] && s_ready[i]) begin
                    if (exp_q[i].size() == 0) chk($sformatf("spurious%0d", i), 0, 1);
                    else begin
                        e  = exp_q[i].pop_front();
                        pc = cyc_q[i].pop_front();
                        chk($sformatf("beat%0d", i), cur[74:0], e);
                        if (lat_chk && i == 0) chk("t1_latency", cyc - pc, 1);
                    end
                end
                if (m_valid[i] && m_ready[i]) begin
                    exp_q[i].push_back({m_data[i], m_keep[i], m_user[i], m_last[i]});
                    cyc_q[i].push_back(cyc);
                end
            end
            if (lat_chk && int'(lvl0) > max_lvl0) max_lvl0 = int'(lvl0);
        end
    end

    task automatic send(int i, logic [74:0] b);
        int t = 0;
        {m_data[i], m_keep[i], m_user[i], m_last[i]} = b;
        m_valid[i] = 1;
        forever begin
            bit acc;
            @(negedge clk);
            acc = m_ready[i];
            @(posedge clk);
            #1;
            if (acc) break;
            if (++t == 500) begin
                chk("send_timeout", acc, 1);
                break;
            end
        end
        m_valid[i] = 0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(int i);
        int t = 0;
        while (exp_q[i].size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk($sformatf("drain%0d", i), exp_q[i].size(), 0);
        idle(2);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0; s_ready[i] = 0; m_data[i] = '0;
            m_keep[i] = '0; m_user[i] = '0; m_last[i] = 0;
        end
        #2;
        chk("rst_mready", m_ready[0], 0);
        chk("rst_svalid", s_valid[0], 0);
        chk("rst_level", lvl0, 0);
        chk("rst_afull", afull[0], 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1 chk("rel_mready", m_ready[0], 1);

        // back-to-back beats through an empty buffer
        s_ready[0] = 1;
        lat_chk = 1;
        send(0, {64'h11, 8'hff, 2'd0, 1'b0});
        send(0, {64'h22, 8'h0f, 2'd1, 1'b0});
        send(0, {64'h33, 8'h01, 2'd2, 1'b1});
        drain(0);
        lat_chk = 0;
        chk("t1_maxlvl", max_lvl0, 1);

        // fill while stalled, offer a fifth beat, then release
        s_ready[0] = 0;
        for (int n = 1; n <= 4; n++) begin
            send(0, {64'(n * 17), 8'hff, 2'(n), 1'(n == 4)});
            chk($sformatf("t2_afull_%0d", n), afull[0], n >= 3);
        end
        chk("t2_level", lvl0, 4);
        chk("t2_mready", m_ready[0], 0);
        fork
            send(0, {64'h55, 8'haa, 2'd3, 1'b1});
            begin
                idle(3);
                chk("t2_hold_level", lvl0, 4);
                chk("t2_hold_ready", m_ready[0], 0);
                s_ready[0] = 1;
            end
        join
        drain(0);

        // random traffic on the depth-8 buffer
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    send(1, {$urandom, $urandom, 8'($urandom), 2'($urandom), 1'($urandom_range(0, 7) == 0)});
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 s_ready[1] = $urandom_range(0, 3) != 0;
                end
                s_ready[1] = 1;
            end
        join
        drain(1);

        // packet mode: output gated until tlast is stored
        s_ready[2] = 1;
        for (int n = 0; n < 3; n++) begin
            send(2, {64'(n + 'h100), 8'hff, 2'(n), 1'(n == 2)});
            if (n < 2) begin
                repeat (2) begin
                    @(negedge clk);
                    chk("t4_gate", s_valid[2], 0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("t4_burst", s_valid[2], 1);
        end
        @(negedge clk);
        chk("t4_done", s_valid[2], 0);
        drain(2);

        // packet longer than the buffer escapes once full
        for (int n = 1; n <= 6; n++) begin
            send(2, {64'(n + 'h200), 8'(n), 2'(n), 1'(n == 6)});
            if (n == 3) chk("t5_closed", s_valid[2], 0);
            if (n == 4) begin
                chk("t5_open", s_valid[2], 1);
                chk("t5_full", lvl2, 4);
            end
        end
        drain(2);
        chk("t5_idle", s_valid[2], 0);

        // asynchronous reset with three beats stored
        s_ready[0] = 0;
        for (int n = 0; n < 3; n++) send(0, {64'(n + 'h300), 8'hff, 2'd0, 1'b0});
        chk("t6_level_pre", lvl0, 3);
        chk("t6_svalid_pre", s_valid[0], 1);
        #2 rst_n = 0;
        #1;
        chk("t6_svalid", s_valid[0], 0);
        chk("t6_mready", m_ready[0], 0);
        chk("t6_level", lvl0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            cyc_q[i].delete();
        end
        @(posedge clk);
        #1 rst_n = 1;
        chk("t6_mready_hold", m_ready[0], 0);
        @(posedge clk);
        #1;
        chk("t6_mready_rel", m_ready[0], 1);
        chk("t6_svalid_rel", s_valid[0], 0);
        chk("t6_level_rel", lvl0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
